lane_mem_arbiter: RTL and testbench

Parametrised data-memory subsystem for the superscalar core: replaces the single-port, always-ready data memory of the single-cycle top with a shared word-addressed storage array serving LANES independent load/store request channels. Requests are arbitrated round-robin, one access per cycle, with a valid/ready handshake, byte-enable writes, an injectable wait-state input and a fixed, parametrised response latency. It sits between the issue lanes' memory stages and the storage array.

---
 rtl/lane_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_lane_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_mem_arbiter.sv
// lane_mem_arbiter
// Shared word-addressed data memory serving LANES load/store request channels.
// One access is granted per cycle by a round-robin arbiter. Each accepted
// request produces exactly one response pulse LATENCY cycles later, and
// responses are returned in accept order.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (clears pointer, pipeline, storage)
//   mem_stall  wait-state injection; blocks every grant in the current cycle
//   req_valid  per-lane request valid
//   req_ready  per-lane accept, at most one bit high
//   req_we     per-lane 1 = store, 0 = load
//   req_addr   per-lane byte address, lane i at [i*ADDR_W +: ADDR_W]
//   req_wdata  per-lane store data
//   req_be     per-lane store byte enables
//   rsp_valid  per-lane one-cycle response pulse
//   rsp_rdata  per-lane load data (zero for store responses and idle lanes)
//   busy       high while any response is in flight
//
// DEPTH is assumed to be a power of two and at least 2.

module lane_mem_arbiter #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_stall,
    input  logic [LANES-1:0]          req_valid,
    output logic [LANES-1:0]          req_ready,
    input  logic [LANES-1:0]          req_we,
    input  logic [LANES*ADDR_W-1:0]   req_addr,
    input  logic [LANES*DATA_W-1:0]   req_wdata,
    input  logic [LANES*DATA_W/8-1:0] req_be,
    output logic [LANES-1:0]          rsp_valid,
    output logic [LANES*DATA_W-1:0]   rsp_rdata,
    output logic                      busy
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              grant_found;
    logic [LANE_W-1:0] grant_lane;
    logic [LANE_W-1:0] cand_lane;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BYTES-1:0]  sel_be;
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic              unused_addr;

    logic              stg_valid_q [LATENCY];
    logic              stg_valid_d [LATENCY];
    logic [LANE_W-1:0] stg_lane_q  [LATENCY];
    logic [LANE_W-1:0] stg_lane_d  [LATENCY];
    logic              stg_we_q    [LATENCY];
    logic              stg_we_d    [LATENCY];
    logic [DATA_W-1:0] stg_data_q  [LATENCY];
    logic [DATA_W-1:0] stg_data_d  [LATENCY];

    // Round-robin search starting at ptr_q; the first valid lane wins.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // before any branch, so no path leaves it holding its old value (latch).
        grant_found = 1'b0;
        grant_lane  = '0;
        cand_lane   = '0;
        for (int k = 0; k < LANES; k++) begin
            cand_lane = LANE_W'((int'(ptr_q) + k) % LANES);
            if (!grant_found && req_valid[cand_lane]) begin
                grant_found = 1'b1;
                grant_lane  = cand_lane;
            end
        end
    end

    // Ready is also gated by reset so nothing looks accepted while reset is low.
    always_comb begin
        req_ready = '0;
        if (grant_found && !mem_stall && reset) begin
            req_ready[grant_lane] = 1'b1;
        end
    end

    assign accept = grant_found & ~mem_stall & reset;

    // Winner's request fields and the read-modify-write word for stores.
    always_comb begin
        sel_we    = req_we[grant_lane];
        sel_addr  = req_addr[int'(grant_lane)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(grant_lane)*DATA_W +: DATA_W];
        sel_be    = req_be[int'(grant_lane)*BYTES +: BYTES];
        // Byte-offset bits and bits above the word index are dropped, so
        // addresses wrap modulo DEPTH words.
        word_idx  = sel_addr[OFF_W +: IDX_W];
        rd_word   = mem_q[word_idx];
        wr_word   = rd_word;
        for (int b = 0; b < BYTES; b++) begin
            if (sel_be[b]) begin
                wr_word[b*8 +: 8] = sel_wdata[b*8 +: 8];
            end
        end
    end

    assign unused_addr = ^sel_addr;

    // Next pointer and response pipeline shift.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = LANE_W'((int'(grant_lane) + 1) % LANES);
        end
        stg_valid_d[0] = accept;
        stg_lane_d[0]  = grant_lane;
        stg_we_d[0]    = sel_we;
        stg_data_d[0]  = rd_word;
        for (int s = 1; s < LATENCY; s++) begin
            stg_valid_d[s] = stg_valid_q[s-1];
            stg_lane_d[s]  = stg_lane_q[s-1];
            stg_we_d[s]    = stg_we_q[s-1];
            stg_data_d[s]  = stg_data_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples values from before the edge, independent of order.
        if (!reset) begin
            ptr_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                stg_valid_q[s] <= 1'b0;
                stg_lane_q[s]  <= '0;
                stg_we_q[s]    <= 1'b0;
                stg_data_q[s]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int s = 0; s < LATENCY; s++) begin
                stg_valid_q[s] <= stg_valid_d[s];
                stg_lane_q[s]  <= stg_lane_d[s];
                stg_we_q[s]    <= stg_we_d[s];
                stg_data_q[s]  <= stg_data_d[s];
            end
        end
    end

    // NOTE: the storage must read back zero after reset, so it is built from
    // resettable flops cleared in one go, not from an uninitialised RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && sel_we) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // Response decode from the last pipeline stage.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        busy      = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            busy = busy | stg_valid_q[s];
        end
        if (stg_valid_q[LATENCY-1]) begin
            rsp_valid[stg_lane_q[LATENCY-1]] = 1'b1;
            if (!stg_we_q[LATENCY-1]) begin
                rsp_rdata[int'(stg_lane_q[LATENCY-1])*DATA_W +: DATA_W] = stg_data_q[LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_lane_mem_arbiter.sv
// Testbench for lane_mem_arbiter. Two instances (LATENCY=1 and LATENCY=3)
// share the same request inputs. A vector table holds inputs, the expected
// req_ready and the expected response data of the accepted request; expected
// responses are queued per instance with their due cycle and compared when
// the instance produces them.

module tb_lane_mem_arbiter;

    typedef struct {
        logic [1:0]  valid;
        logic        stall;
        logic [1:0]  we;
        logic [31:0] addr0;
        logic [31:0] wd0;
        logic [3:0]  be0;
        logic [31:0] addr1;
        logic [31:0] wd1;
        logic [3:0]  be1;
        logic [1:0]  exp_ready;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          lane;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_stall;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;

    logic [1:0]  req_ready1, req_ready3;
    logic [1:0]  rsp_valid1, rsp_valid3;
    logic [63:0] rsp_rdata1, rsp_rdata3;
    logic        busy1, busy3;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t q1[$];
    exp_t q3[$];
    vec_t vecs[$];

    lane_mem_arbiter #(.LANES(2), .DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_stall(mem_stall),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1)
    );

    lane_mem_arbiter #(.LANES(2), .DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_stall(mem_stall),
        .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compares one instance's response outputs against its queue front.
    task automatic mon(input string tag, input logic [1:0] rv, input logic [63:0] rd,
                       input bit have, input exp_t e, output bit pop);
        logic [63:0] w;
        pop = 1'b0;
        w   = '0;
        if (have && e.due == cyc) begin
            pop = 1'b1;
            w[e.lane*32 +: 32] = e.data;
            check({tag, " rsp_valid"}, {62'd0, rv}, 64'd1 << e.lane);
            check({tag, " rsp_rdata"}, rd, w);
        end else if (rv != 2'b00) begin
            check({tag, " unexpected rsp_valid"}, {62'd0, rv}, 64'd0);
        end else if (rd != 64'd0) begin
            check({tag, " idle rsp_rdata"}, rd, 64'd0);
        end
    endtask

    always @(negedge clk) begin : mon_blk
        bit   p;
        exp_t e;
        e = '{lane: 0, data: 32'd0, due: -1};
        if (q1.size() != 0) e = q1[0];
        mon("L1", rsp_valid1, rsp_rdata1, q1.size() != 0, e, p);
        if (p) void'(q1.pop_front());
        e = '{lane: 0, data: 32'd0, due: -1};
        if (q3.size() != 0) e = q3[0];
        mon("L3", rsp_valid3, rsp_rdata3, q3.size() != 0, e, p);
        if (p) void'(q3.pop_front());
    end

    function automatic vec_t mk(input logic [1:0] valid, input logic stall, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] wd0, input logic [3:0] be0,
                                input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] be1,
                                input logic [1:0] er, input logic [31:0] ed);
        vec_t v;
        v.valid = valid; v.stall = stall; v.we = we;
        v.addr0 = a0; v.wd0 = wd0; v.be0 = be0;
        v.addr1 = a1; v.wd1 = wd1; v.be1 = be1;
        v.exp_ready = er; v.exp_data = ed;
        return v;
    endfunction

    // Drives one vector for one cycle, checks ready, queues expected responses.
    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        req_valid = v.valid;
        mem_stall = v.stall;
        req_we    = v.we;
        req_addr  = {v.addr1, v.addr0};
        req_wdata = {v.wd1, v.wd0};
        req_be    = {v.be1, v.be0};
        @(negedge clk);
        check({tag, " req_ready L1"}, {62'd0, req_ready1}, {62'd0, v.exp_ready});
        check({tag, " req_ready L3"}, {62'd0, req_ready3}, {62'd0, v.exp_ready});
        if ((v.exp_ready & v.valid) != 2'b00) begin
            q1.push_back('{lane: (v.exp_ready[1] ? 1 : 0), data: v.exp_data, due: cyc + 1});
            q3.push_back('{lane: (v.exp_ready[1] ? 1 : 0), data: v.exp_data, due: cyc + 3});
        end
    endtask

    task automatic drive_idle();
        req_valid = 2'b00;
        mem_stall = 1'b0;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Reset state, with requests pending to exercise ready gating.
        reset = 1'b0;
        drive_idle();
        req_valid = 2'b11;
        #2;
        check("reset req_ready L1", {62'd0, req_ready1}, 64'd0);
        check("reset req_ready L3", {62'd0, req_ready3}, 64'd0);
        check("reset rsp_valid L1", {62'd0, rsp_valid1}, 64'd0);
        check("reset rsp_rdata L3", rsp_rdata3, 64'd0);
        check("reset busy L1", {63'd0, busy1}, 64'd0);
        check("reset busy L3", {63'd0, busy3}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;

        // valid stall we   a0        wd0           be0   a1     wd1           be1   rdy    data
        vecs.push_back(mk(2'b01, 0, 2'b01, 'h10,  'hDEADBEEF, 'hF, 'h0,  'h0,         'h0, 2'b01, 'h0));
        vecs.push_back(mk(2'b01, 0, 2'b00, 'h10,  'h0,        'h0, 'h0,  'h0,         'h0, 2'b01, 'hDEADBEEF));
        vecs.push_back(mk(2'b01, 0, 2'b01, 'h20,  'h11223344, 'hF, 'h0,  'h0,         'h0, 2'b01, 'h0));
        vecs.push_back(mk(2'b01, 0, 2'b01, 'h20,  'hAABBCCDD, 'h5, 'h0,  'h0,         'h0, 2'b01, 'h0));
        vecs.push_back(mk(2'b01, 0, 2'b00, 'h20,  'h0,        'h0, 'h0,  'h0,         'h0, 2'b01, 'h11BB33DD));
        vecs.push_back(mk(2'b10, 0, 2'b00, 'h0,   'h0,        'h0, 'h10, 'h0,         'h0, 2'b10, 'hDEADBEEF));
        // Contention: grants alternate 0,1,0,1,0,1.
        vecs.push_back(mk(2'b11, 0, 2'b10, 'h20,  'h0,        'h0, 'h30, 'hCAFEF00D,  'hF, 2'b01, 'h11BB33DD));
        vecs.push_back(mk(2'b11, 0, 2'b10, 'h30,  'h0,        'h0, 'h30, 'hCAFEF00D,  'hF, 2'b10, 'h0));
        vecs.push_back(mk(2'b11, 0, 2'b00, 'h30,  'h0,        'h0, 'h30, 'h0,         'h0, 2'b01, 'hCAFEF00D));
        vecs.push_back(mk(2'b11, 0, 2'b01, 'h34,  'h77,       'h1, 'h30, 'h0,         'h0, 2'b10, 'hCAFEF00D));
        vecs.push_back(mk(2'b11, 0, 2'b01, 'h34,  'h77,       'h1, 'h34, 'h0,         'h0, 2'b01, 'h0));
        vecs.push_back(mk(2'b11, 0, 2'b00, 'h34,  'h0,        'h0, 'h34, 'h0,         'h0, 2'b10, 'h77));
        // Wait states on lane 1, then release.
        vecs.push_back(mk(2'b10, 1, 2'b00, 'h0,   'h0,        'h0, 'h10, 'h0,         'h0, 2'b00, 'h0));
        vecs.push_back(mk(2'b10, 1, 2'b00, 'h0,   'h0,        'h0, 'h10, 'h0,         'h0, 2'b00, 'h0));
        vecs.push_back(mk(2'b10, 1, 2'b00, 'h0,   'h0,        'h0, 'h10, 'h0,         'h0, 2'b00, 'h0));
        vecs.push_back(mk(2'b10, 0, 2'b00, 'h0,   'h0,        'h0, 'h10, 'h0,         'h0, 2'b10, 'hDEADBEEF));
        vecs.push_back(mk(2'b11, 0, 2'b00, 'h10,  'h0,        'h0, 'h20, 'h0,         'h0, 2'b01, 'hDEADBEEF));
        // Address wrap and ignored byte offset.
        vecs.push_back(mk(2'b01, 0, 2'b01, 'h100, 'h5,        'hF, 'h0,  'h0,         'h0, 2'b01, 'h0));
        vecs.push_back(mk(2'b01, 0, 2'b00, 'h2,   'h0,        'h0, 'h0,  'h0,         'h0, 2'b01, 'h5));
        vecs.push_back(mk(2'b00, 0, 2'b00, 'h0,   'h0,        'h0, 'h0,  'h0,         'h0, 2'b00, 'h0));
        // Request withdrawn while stalled: no response.
        vecs.push_back(mk(2'b01, 1, 2'b00, 'h10,  'h0,        'h0, 'h0,  'h0,         'h0, 2'b00, 'h0));
        vecs.push_back(mk(2'b00, 0, 2'b00, 'h0,   'h0,        'h0, 'h0,  'h0,         'h0, 2'b00, 'h0));
        // Store with no byte enables still responds and leaves the word alone.
        vecs.push_back(mk(2'b10, 0, 2'b10, 'h0,   'h0,        'h0, 'h10, 'hFFFFFFFF,  'h0, 2'b10, 'h0));
        vecs.push_back(mk(2'b10, 0, 2'b00, 'h0,   'h0,        'h0, 'h10, 'h0,         'h0, 2'b10, 'hDEADBEEF));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end
        repeat (5) idle_cycle();

        // Latency / busy: single load accepted at the next edge.
        apply(mk(2'b01, 0, 2'b00, 'h0, 'h0, 'h0, 'h0, 'h0, 'h0, 2'b01, 'h5), "lat");
        for (int k = 1; k <= 4; k++) begin
            idle_cycle();
            check($sformatf("busy L1 +%0d", k), {63'd0, busy1}, {63'd0, (k == 1)});
            check($sformatf("busy L3 +%0d", k), {63'd0, busy3}, {63'd0, (k <= 3)});
        end
        repeat (2) idle_cycle();

        // Reset one cycle after a load accept: LATENCY=3 responses are lost.
        apply(mk(2'b01, 0, 2'b01, 'h40, 'h12345678, 'hF, 'h0, 'h0, 'h0, 2'b01, 'h0), "rst st");
        apply(mk(2'b01, 0, 2'b00, 'h40, 'h0, 'h0, 'h0, 'h0, 'h0, 2'b01, 'h12345678), "rst ld");
        idle_cycle();
        #2;
        req_valid = 2'b11;
        reset = 1'b0;
        #1;
        check("mid reset req_ready L3", {62'd0, req_ready3}, 64'd0);
        check("mid reset rsp_valid L3", {62'd0, rsp_valid3}, 64'd0);
        check("mid reset rsp_rdata L3", rsp_rdata3, 64'd0);
        check("mid reset busy L3", {63'd0, busy3}, 64'd0);
        check("mid reset busy L1", {63'd0, busy1}, 64'd0);
        q1.delete();
        q3.delete();
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        repeat (4) idle_cycle();

        // Storage was cleared: earlier stores read back zero; ptr restarted at 0.
        apply(mk(2'b01, 0, 2'b00, 'h40, 'h0, 'h0, 'h0,  'h0, 'h0, 2'b01, 'h0), "post ld40");
        apply(mk(2'b10, 0, 2'b00, 'h0,  'h0, 'h0, 'h10, 'h0, 'h0, 2'b10, 'h0), "post ld10");
        apply(mk(2'b01, 0, 2'b00, 'h2,  'h0, 'h0, 'h0,  'h0, 'h0, 2'b01, 'h0), "post ld0");
        repeat (6) idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
